pipe_hazard_ctrl: RTL

Central sequencing controller for the 5-stage RV32I pipeline. Drives the act (valid/bubble) and hold inputs of the IF_ID, ID_EX, EX_MEM and MEM_WAR stage registers. Detects load-use hazards, squashes wrong-path instructions on a branch or jump redirect from EX, and freezes the pipeline while the data memory handshake is outstanding. Keeps performance counters and a sticky memory-timeout error.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 17 +
 rtl/pipe_hazard_ctrl_if.sv | 41 ++++
 rtl/pipe_hazard_ctrl_sat_counter.sv | 29 ++
 rtl/pipe_hazard_ctrl.sv | 132 +++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and opcode constants for the RV32I pipeline hazard controller.
package pipe_pkg;

   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;

   typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} mem_state_t;

   typedef struct packed {
      logic hold;
      logic act;
   } stage_ctrl_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side signals of the hazard controller: stage info in, stage control out.
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 32);

   logic [4:0]       IFID_rs1;
   logic [4:0]       IFID_rs2;
   logic             IFID_rs1_used;
   logic             IFID_rs2_used;
   logic [6:0]       IDEX_opcode_out;
   logic [4:0]       IDEX_write_reg_out;
   logic             IDEX_register_write_valid_out;
   logic             ex_pc_replace;
   logic [6:0]       EXMEM_opcode_out;
   logic             EXMEM_valid;
   logic             mem_ready;
   logic             pc_hold;
   logic             IFID_hold;
   logic             IFID_act;
   logic             IDEX_act;
   logic             pipe_hold;
   logic             mem_req;
   logic             mem_error;
   logic [CNT_W-1:0] stall_cycles;
   logic [CNT_W-1:0] flush_count;

   modport master (
      output IFID_rs1, IFID_rs2, IFID_rs1_used, IFID_rs2_used,
             IDEX_opcode_out, IDEX_write_reg_out, IDEX_register_write_valid_out,
             ex_pc_replace, EXMEM_opcode_out, EXMEM_valid, mem_ready,
      input  pc_hold, IFID_hold, IFID_act, IDEX_act, pipe_hold, mem_req,
             mem_error, stall_cycles, flush_count
   );

   modport slave (
      input  IFID_rs1, IFID_rs2, IFID_rs1_used, IFID_rs2_used,
             IDEX_opcode_out, IDEX_write_reg_out, IDEX_register_write_valid_out,
             ex_pc_replace, EXMEM_opcode_out, EXMEM_valid, mem_ready,
      output pc_hold, IFID_hold, IFID_act, IDEX_act, pipe_hold, mem_req,
             mem_error, stall_cycles, flush_count
   );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr)
         count_d = '0;
      else if (inc && (count_q != '1))
         count_d = count_q + W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: load-use stall,
// EX redirect squash, data-memory freeze with timeout, and perf counters.
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 32
) (
   input logic               clk,
   input logic               reset,
   pipe_hazard_ctrl_if.slave bus
);

   localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);

   mem_state_t        state_q, state_d;
   logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;

   logic        mem_req;
   logic        freeze;
   logic        load_use;
   logic        rs1_hit, rs2_hit;
   logic        redirect_go;
   logic        pc_hold;
   stage_ctrl_t ifid, idex;

   always_comb begin
      mem_req = bus.EXMEM_valid &&
                ((bus.EXMEM_opcode_out == LOAD) || (bus.EXMEM_opcode_out == STORE));
   end

   // x0 is excluded by the rd != 0 term, so a match on x0 never stalls
   always_comb begin
      rs1_hit  = bus.IFID_rs1_used && (bus.IFID_rs1 == bus.IDEX_write_reg_out);
      rs2_hit  = bus.IFID_rs2_used && (bus.IFID_rs2 == bus.IDEX_write_reg_out);
      load_use = (bus.IDEX_opcode_out == LOAD) && bus.IDEX_register_write_valid_out &&
                 (bus.IDEX_write_reg_out != 5'd0) && (rs1_hit || rs2_hit);
   end

   always_comb begin
      freeze = ((state_q == MEM_WAIT) && !bus.mem_ready) ||
               ((state_q == RUN) && mem_req && !bus.mem_ready) ||
               (state_q == ERROR);
      redirect_go = bus.ex_pc_replace && !freeze;
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      case (state_q)
         RUN: begin
            if (mem_req && !bus.mem_ready) begin
               state_d    = MEM_WAIT;
               wait_cnt_d = WCNT_W'(1);
            end
         end
         MEM_WAIT: begin
            if (bus.mem_ready) begin
               state_d    = RUN;
               wait_cnt_d = '0;
            end else if (wait_cnt_q == WCNT_W'(MEM_TIMEOUT)) begin
               state_d = ERROR;
            end else begin
               wait_cnt_d = wait_cnt_q + WCNT_W'(1);
            end
         end
         ERROR:   state_d = ERROR;
         default: begin
            state_d    = RUN;
            wait_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= RUN;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // idex.hold doubles as the shared hold for ID_EX, EX_MEM and MEM_WB
   always_comb begin
      pc_hold = 1'b0;
      ifid    = '{hold: 1'b0, act: 1'b1};
      idex    = '{hold: 1'b0, act: 1'b1};
      if (reset) begin
         pc_hold  = 1'b1;
         ifid.act = 1'b0;
         idex.act = 1'b0;
      end else if (freeze) begin
         pc_hold   = 1'b1;
         ifid.hold = 1'b1;
         idex.hold = 1'b1;
      end else if (bus.ex_pc_replace) begin
         ifid.act = 1'b0;
         idex.act = 1'b0;
      end else if (load_use) begin
         pc_hold   = 1'b1;
         ifid.hold = 1'b1;
         idex.act  = 1'b0;
      end
   end

   assign bus.pc_hold   = pc_hold;
   assign bus.IFID_hold = ifid.hold;
   assign bus.IFID_act  = ifid.act;
   assign bus.IDEX_act  = idex.act;
   assign bus.pipe_hold = idex.hold;
   assign bus.mem_req   = mem_req;
   assign bus.mem_error = (state_q == ERROR);

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (reset),
      .inc   (pc_hold && (state_q != ERROR)),
      .clr   (1'b0),
      .count (bus.stall_cycles)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (reset),
      .inc   (redirect_go),
      .clr   (1'b0),
      .count (bus.flush_count)
   );

endmodule
